// File: rtl/uart_rx_frontend.sv
// UART receiver front end: RX synchronizer, start/data/stop/break FSM and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rxs
// S_START | half-bit wait, then re-check the start bit (false-start filter)
// S_DATA  | sample 8 data bits LSB first, one per bit period
// S_STOP  | sample the stop bit; good stop pushes the byte
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

    logic        rx_meta_q, rxs_q;
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        push;
    logic        tc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= RX;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign tc = (timer_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    timer_d = HALF_BIT;
                end
            end
            S_START: begin
                if (!tc) begin
                    timer_d = timer_q - 16'd1;
                end else if (!rxs_q) begin
                    state_d = S_DATA;
                    timer_d = FULL_BIT;
                    idx_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tc) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    shift_d[idx_q] = rxs_q;
                    timer_d        = FULL_BIT;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (!tc) begin
                    timer_d = timer_q - 16'd1;
                end else if (rxs_q) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY      = (state_q != S_IDLE);
        FRAME_ERR = frame_err_q;
        OVERRUN   = overrun_q;
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty, full, pop, push_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign pop     = !empty && READY;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && (!full || pop);

    always_comb begin
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        overrun_d = push && full && !pop;
        if (push_ok) begin
            mem_d[wr_q] = shift_q;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign VALID = !empty;
    assign DATA  = empty ? 8'h00 : mem_q[rd_q];
`else
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic       pop;

    assign pop = full_q && READY;

    always_comb begin
        hold_d    = hold_q;
        full_d    = full_q;
        overrun_d = 1'b0;
        if (push && (!full_q || pop)) begin
            hold_d = shift_q;
            full_d = 1'b1;
        end else if (push) begin
            overrun_d = 1'b1;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_q    <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    assign VALID = full_q;
    assign DATA  = full_q ? hold_q : 8'h00;
`endif

endmodule
